// File: rtl/pixel_array_pkg.sv
// pixel_array_pkg: shared state encoding and default phase lengths for the pixel array sequencer.
package pixel_array_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_RSEL,
    S_CAPTURE,
    S_STREAM
  } state_t;
  localparam int C_ERASE_DEF = 5;
  localparam int C_EXPOSE_DEF = 255;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/pixel_row_buffer.sv
// pixel_row_buffer: captures one full row from the array bus and presents a selected column.
module pixel_row_buffer #(
  parameter int COLS = 2,
  parameter int DW = 8,
  parameter int CLW = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [COLS*DW-1:0] pix_i,
  input  logic [CLW-1:0]     col_i,
  output logic [DW-1:0]      data_o
);
  logic [COLS*DW-1:0] row_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) row_q <= '0;
    else if (load_i) row_q <= pix_i;
  assign data_o = row_q[col_i*DW +: DW];
endmodule

// File: rtl/pixel_array_seq.sv
// pixel_array_seq: erase/expose/convert sequencing of a pixel array, then row-by-row readout
// streamed one pixel per beat over a valid/ready interface.
module pixel_array_seq
  import pixel_array_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int DW = 8,
  parameter int C_ERASE = C_ERASE_DEF,
  parameter int C_EXPOSE = C_EXPOSE_DEF,
  parameter int C_CONVERT = 2**DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               erase,
  output logic               expose,
  output logic               convert,
  output logic [ROWS-1:0]    read,
  output logic [DW-1:0]      adc_cnt,
  output logic               adc_cnt_en,
  input  logic [COLS*DW-1:0] pix_bus,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);
  localparam int CW = $clog2(max3(C_ERASE, C_EXPOSE, C_CONVERT) + 1);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] E_LAST = CW'(C_ERASE - 1);
  localparam logic [CW-1:0] X_LAST = CW'(C_EXPOSE - 1);
  localparam logic [CW-1:0] V_LAST = CW'(C_CONVERT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, phase_last;
  logic [RW-1:0] row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic erase_q, expose_q, convert_q, valid_q, last_q, busy_q;
  logic [ROWS-1:0] read_q;
  logic [DW-1:0] adc_q;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    row_d = row_q;
    col_d = col_q;
    phase_last = st_q == S_ERASE ? E_LAST : st_q == S_EXPOSE ? X_LAST : V_LAST;
    case (st_q)
      S_IDLE: if (start) begin
        st_d = S_ERASE;
        cnt_d = '0;
      end
      S_ERASE, S_EXPOSE, S_CONVERT: if (cnt_q == phase_last) begin
        cnt_d = '0;
        row_d = '0;
        st_d = st_q == S_ERASE ? S_EXPOSE : st_q == S_EXPOSE ? S_CONVERT : S_RSEL;
      end else cnt_d = cnt_q + 1'b1;
      S_RSEL: st_d = S_CAPTURE;
      S_CAPTURE: begin
        st_d = S_STREAM;
        col_d = '0;
      end
      S_STREAM: if (out_ready) begin
        if (col_q != COL_LAST) col_d = col_q + 1'b1;
        else if (row_q != ROW_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
          st_d = S_RSEL;
        end else begin
          col_d = '0;
          st_d = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they align with the state they describe.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      row_q <= '0;
      col_q <= '0;
      erase_q <= 1'b0;
      expose_q <= 1'b0;
      convert_q <= 1'b0;
      adc_q <= '0;
      read_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      col_q <= col_d;
      erase_q <= st_d == S_ERASE;
      expose_q <= st_d == S_EXPOSE;
      convert_q <= st_d == S_CONVERT;
      adc_q <= st_d == S_CONVERT ? DW'(cnt_d) : '0;
      read_q <= (st_d == S_RSEL || st_d == S_CAPTURE) ? ROWS'(1) << row_d : '0;
      valid_q <= st_d == S_STREAM;
      last_q <= st_d == S_STREAM && row_d == ROW_LAST && col_d == COL_LAST;
      busy_q <= st_d != S_IDLE;
    end
  pixel_row_buffer #(.COLS(COLS), .DW(DW), .CLW(CLW)) u_buf (
    .clk_i(clk),
    .rst_i(reset),
    .load_i(st_q == S_CAPTURE),
    .pix_i(pix_bus),
    .col_i(col_q),
    .data_o(out_data)
  );
  assign erase = erase_q;
  assign expose = expose_q;
  assign convert = convert_q;
  assign read = read_q;
  assign adc_cnt = adc_q;
  assign adc_cnt_en = convert_q;
  assign out_valid = valid_q;
  assign out_last = last_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_pixel_array_seq.sv
// tb_pixel_array_seq: scoreboard bench for the default 2x2 array and a 4x3, 10-bit array.
module tb_pixel_array_seq;
  typedef struct packed {
    logic [31:0] d;
    logic last;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic rst_a, start_a, ready_a, erase_a, expose_a, convert_a, adc_en_a, valid_a, last_a, busy_a;
  logic [1:0] read_a;
  logic [7:0] adc_a, data_a;
  logic [15:0] pix_a;
  logic [15:0] rows_a[2];
  exp_t q_a[$];
  assign pix_a = read_a[1] ? rows_a[1] : read_a[0] ? rows_a[0] : 16'h0;
  pixel_array_seq dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .erase(erase_a), .expose(expose_a),
    .convert(convert_a), .read(read_a), .adc_cnt(adc_a), .adc_cnt_en(adc_en_a),
    .pix_bus(pix_a), .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_last(last_a), .busy(busy_a)
  );
  logic rst_b, start_b, ready_b, erase_b, expose_b, convert_b, adc_en_b, valid_b, last_b, busy_b;
  logic [3:0] read_b;
  logic [9:0] adc_b, data_b;
  logic [29:0] pix_b;
  logic [29:0] rows_b[4];
  exp_t q_b[$];
  always_comb begin
    pix_b = '0;
    for (int r = 0; r < 4; r++) if (read_b[r]) pix_b = rows_b[r];
  end
  pixel_array_seq #(.ROWS(4), .COLS(3), .DW(10), .C_ERASE(2), .C_EXPOSE(3), .C_CONVERT(8)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .erase(erase_b), .expose(expose_b),
    .convert(convert_b), .read(read_b), .adc_cnt(adc_b), .adc_cnt_en(adc_en_b),
    .pix_bus(pix_b), .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_last(last_b), .busy(busy_b)
  );
  int ers_n, exp_n, cnv_n, busy_n, beats_n, lasts_n, run_a;
  logic pv_a = 1'b0, pr_a = 1'b1;
  logic [7:0] pd_a;
  always @(negedge clk) begin
    exp_t e;
    ers_n += int'(erase_a);
    exp_n += int'(expose_a);
    cnv_n += int'(convert_a);
    busy_n += int'(busy_a);
    chk("adc_a", adc_a, convert_a ? run_a : 0);
    chk("adc_en_a", adc_en_a, convert_a);
    run_a = convert_a ? run_a + 1 : 0;
    chk("excl_a", $countones({erase_a, expose_a, convert_a, |read_a}) <= 1, 1);
    chk("onehot_a", $onehot0(read_a), 1);
    if (!valid_a) chk("last_nv_a", last_a, 0);
    if (pv_a && !pr_a) begin
      chk("hold_v_a", valid_a, 1);
      chk("hold_d_a", data_a, pd_a);
    end
    if (valid_a && ready_a) begin
      beats_n++;
      lasts_n += int'(last_a);
      if (q_a.size() == 0) chk("extra_a", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("data_a", data_a, e.d);
        chk("last_a", last_a, e.last);
      end
    end
    pv_a = valid_a;
    pr_a = ready_a;
    pd_a = data_a;
  end
  int beats_b, lasts_b, rows_seen_b, row_exp_b;
  logic [3:0] prev_read_b = '0;
  always @(negedge clk) begin
    exp_t e;
    chk("onehot_b", $onehot0(read_b), 1);
    if (!valid_b) chk("last_nv_b", last_b, 0);
    if (read_b != 0 && read_b != prev_read_b) begin
      chk("row_b", read_b, 4'b1 << row_exp_b);
      row_exp_b = (row_exp_b + 1) % 4;
      rows_seen_b++;
    end
    prev_read_b = read_b;
    if (valid_b && ready_b) begin
      beats_b++;
      lasts_b += int'(last_b);
      if (q_b.size() == 0) chk("extra_b", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("data_b", data_b, e.d);
        chk("last_b", last_b, e.last);
      end
    end
  end
  task automatic push(input bit b, input int d, input bit l);
    exp_t e;
    e.d = d;
    e.last = l;
    if (b) q_b.push_back(e);
    else q_a.push_back(e);
  endtask
  task automatic zero_a(input string tag);
    chk({tag, "_erase"}, erase_a, 0);
    chk({tag, "_expose"}, expose_a, 0);
    chk({tag, "_convert"}, convert_a, 0);
    chk({tag, "_read"}, read_a, 0);
    chk({tag, "_adc"}, adc_a, 0);
    chk({tag, "_adc_en"}, adc_en_a, 0);
    chk({tag, "_valid"}, valid_a, 0);
    chk({tag, "_last"}, last_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_data"}, data_a, 0);
  endtask
  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask
  task automatic frame_a(input logic [15:0] r0, input logic [15:0] r1, input bit bp, input bit pokes);
    int e0, x0, c0, b0, n0, l0, n;
    rows_a[0] = r0;
    rows_a[1] = r1;
    push(0, r0[7:0], 0);
    push(0, r0[15:8], 0);
    push(0, r1[7:0], 0);
    push(0, r1[15:8], 1);
    e0 = ers_n; x0 = exp_n; c0 = cnv_n; b0 = busy_n; n0 = beats_n; l0 = lasts_n;
    tick();
    pulse_start_a();
    @(negedge clk);
    chk("erase_t1", erase_a, 1);
    chk("busy_t1", busy_a, 1);
    tick();
    if (pokes) begin
      n = 0;
      while (!expose_a && n < 100) begin tick(); n++; end
      if (!expose_a) chk("tmo_expose", 0, 1);
      pulse_start_a();
    end
    if (bp) begin
      n = 0;
      while (beats_n - n0 < 1 && n < 2000) begin tick(); n++; end
      if (beats_n - n0 < 1) chk("tmo_beat1", 0, 1);
      ready_a = 1'b0;
      repeat (3) tick();
      ready_a = 1'b1;
    end
    if (pokes) begin
      n = 0;
      while (!valid_a && n < 2000) begin tick(); n++; end
      if (!valid_a) chk("tmo_valid", 0, 1);
      pulse_start_a();
      n = 0;
      while (!last_a && n < 100) begin tick(); n++; end
      if (!last_a) chk("tmo_last", 0, 1);
      pulse_start_a();
    end
    n = 0;
    while (busy_a && n < 2000) begin tick(); n++; end
    if (busy_a) chk("tmo_idle", 0, 1);
    chk("erase_len", ers_n - e0, 5);
    chk("expose_len", exp_n - x0, 255);
    chk("convert_len", cnv_n - c0, 256);
    chk("busy_len", busy_n - b0, bp ? 524 + 3 : 524);
    chk("beats", beats_n - n0, 4);
    chk("lasts", lasts_n - l0, 1);
    chk("sb_empty_a", q_a.size(), 0);
    if (pokes) begin
      repeat (10) tick();
      chk("idle_stay", busy_a, 0);
      chk("no_extra", beats_n - n0, 4);
    end
  endtask
  task automatic reset_mid_a();
    int n = 0;
    rows_a[0] = 16'h0f0f;
    rows_a[1] = 16'hf0f0;
    tick();
    pulse_start_a();
    while (!(convert_a && adc_a == 8'd100) && n < 1000) begin tick(); n++; end
    if (!(convert_a && adc_a == 8'd100)) chk("tmo_adc100", 0, 1);
    rst_a = 1'b1;
    #1;
    zero_a("midrst");
    tick();
    tick();
    rst_a = 1'b0;
    repeat (3) tick();
    chk("midrst_idle", busy_a, 0);
  endtask
  task automatic frame_b();
    int n0, l0, s0, n;
    for (int r = 0; r < 4; r++) begin
      rows_b[r] = 30'($urandom);
      for (int c = 0; c < 3; c++) push(1, rows_b[r][c*10 +: 10], r == 3 && c == 2);
    end
    n0 = beats_b; l0 = lasts_b; s0 = rows_seen_b;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 500) begin
      ready_b = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ready_b = 1'b1;
    if (busy_b) chk("tmo_idle_b", 0, 1);
    chk("beats_b", beats_b - n0, 12);
    chk("lasts_b", lasts_b - l0, 1);
    chk("rows_b", rows_seen_b - s0, 4);
    chk("sb_empty_b", q_b.size(), 0);
  endtask
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    rows_a[0] = '0; rows_a[1] = '0;
    for (int r = 0; r < 4; r++) rows_b[r] = '0;
    ers_n = 0; exp_n = 0; cnv_n = 0; busy_n = 0; beats_n = 0; lasts_n = 0; run_a = 0;
    beats_b = 0; lasts_b = 0; rows_seen_b = 0; row_exp_b = 0;
    repeat (2) @(negedge clk);
    zero_a("rst");
    chk("rst_busy_b", busy_b, 0);
    chk("rst_read_b", read_b, 0);
    chk("rst_valid_b", valid_b, 0);
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    frame_a(16'h2211, 16'h4433, 0, 0);
    frame_a(16'ha1b2, 16'hc3d4, 1, 0);
    frame_a(16'h5566, 16'h7788, 0, 1);
    reset_mid_a();
    frame_a(16'h99aa, 16'hbbcc, 0, 0);
    frame_b();
    frame_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pixel_array_seq.md
PIXEL_ARRAY_SEQ -- requirements
Module: pixel_array_seq

Interface
REQ-001 Parameter ROWS, default 2: number of pixel rows; SHALL be at least 1.
REQ-002 Parameter COLS, default 2: pixels per row; SHALL be at least 1.
REQ-003 Parameter DW, default 8: pixel data width in bits.
REQ-004 Parameter C_ERASE, default 5: erase phase length in cycles; SHALL be at least 1.
REQ-005 Parameter C_EXPOSE, default 255: expose phase length in cycles; SHALL be at least 1.
REQ-006 Parameter C_CONVERT, default 2**DW: ADC ramp length in cycles; SHALL be at most 2**DW.
REQ-007 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port start, input, 1: frame request, sampled only in IDLE.
REQ-010 Port erase, output, 1: pixel erase strobe.
REQ-011 Port expose, output, 1: pixel expose strobe.
REQ-012 Port convert, output, 1: ramp enable during conversion.
REQ-013 Port read, output, ROWS: one-hot row select for the array data bus.
REQ-014 Port adc_cnt, output, DW: ramp code that the pixels latch during conversion.
REQ-015 Port adc_cnt_en, output, 1: adc_cnt is valid and driven.
REQ-016 Port pix_bus, input, COLS*DW: selected row data; column c occupies bits [c*DW +: DW].
REQ-017 Port out_data, output, DW: streamed pixel value.
REQ-018 Port out_valid, output, 1: out_data is valid.
REQ-019 Port out_ready, input, 1: downstream accepts the pixel.
REQ-020 Port out_last, output, 1: the current beat is the final pixel of the frame.
REQ-021 Port busy, output, 1: high in every state except IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, ERASE, EXPOSE, CONVERT, RSEL, CAPTURE and STREAM.
REQ-023 When start is high in IDLE at edge T, the FSM SHALL enter ERASE, and erase SHALL be high for exactly C_ERASE cycles beginning at T+1.
REQ-024 The FSM SHALL go from ERASE to EXPOSE, with expose high for exactly C_EXPOSE cycles.
REQ-025 The FSM SHALL go from EXPOSE to CONVERT.
REQ-026 In CONVERT, convert and adc_cnt_en SHALL be high, and adc_cnt SHALL run 0, 1, ..., C_CONVERT-1 (one step per cycle) before the FSM moves to RSEL with row index 0.
REQ-027 Outside CONVERT, adc_cnt SHALL be 0 and adc_cnt_en SHALL be 0.
REQ-028 RSEL SHALL last one cycle with read[row] high, to let the bus settle.
REQ-029 CAPTURE SHALL last one cycle with read[row] still high; at its end, pix_bus SHALL be registered into the row buffer.
REQ-030 After CAPTURE, read SHALL be all-zero, and the FSM SHALL enter STREAM with column index 0.
REQ-031 In STREAM, out_valid SHALL be high and out_data SHALL equal buffered column col.
REQ-032 A beat SHALL complete only on a cycle where out_valid and out_ready are both high.
REQ-033 While out_ready is low, out_data and out_valid SHALL hold their values.
REQ-034 After the beat for column COLS-1: if row is less than ROWS-1, the FSM SHALL increment row and go to RSEL; otherwise it SHALL go to IDLE.
REQ-035 out_last SHALL be high only while out_valid is high at row ROWS-1 and column COLS-1.
REQ-036 start SHALL be ignored in every state except IDLE; no request is queued.
REQ-037 A start arriving on the same edge as the final beat SHALL be ignored; start is accepted from the next IDLE cycle.
REQ-038 With out_ready held high, one frame SHALL take exactly 1 + C_ERASE + C_EXPOSE + C_CONVERT + ROWS*(2+COLS) cycles from the start edge back to IDLE (busy low).
REQ-039 The outputs erase, expose, convert and read SHALL be mutually exclusive, and each SHALL be registered.

Reset
REQ-040 While reset is high, the FSM SHALL be in IDLE.
REQ-041 While reset is high, erase, expose, convert, adc_cnt_en, out_valid, out_last and busy SHALL be 0.
REQ-042 While reset is high, read SHALL be all-zero, adc_cnt SHALL be 0, out_data SHALL be 0, all counters SHALL be 0, and the row buffer SHALL be cleared.
REQ-043 Reset asserted mid-frame SHALL abort the frame immediately; no partial beat SHALL be emitted after reset is deasserted.

Structure
REQ-044 The package pixel_array_pkg SHALL hold the state enum typedef and the default phase-length constants.
REQ-045 The sub-module pixel_row_buffer SHALL implement capture of COLS*DW bits and indexed column select; the FSM and counters SHALL stay in pixel_array_seq.
REQ-046 Counter widths SHALL be derived with $clog2 from the parameters.

Verification
REQ-047 Scenario (defaults, ready always high): start pulse -> erase for 5 cycles, expose for 255, adc_cnt 0..255, then 4 beats with out_last on the 4th; busy falls at cycle 1+5+255+256+8.
REQ-048 Scenario (ROWS=2, COLS=2): pix_bus = 0x2211 for row 0 and 0x4433 for row 1 -> out_data sequence 0x11, 0x22, 0x33, 0x44.
REQ-049 Scenario (backpressure): out_ready low for 3 cycles on beat 2 -> out_data is stable and out_valid stays high; there is no duplicate or lost beat.
REQ-050 Scenario (start while busy): start pulsed during EXPOSE and during STREAM -> no effect; exactly one frame is produced.
REQ-051 Scenario (mid-frame reset): reset asserted during CONVERT at adc_cnt=100 -> all outputs are 0 the same cycle, and a following start runs a full, clean frame.
REQ-052 Scenario (ROWS=4, COLS=3, DW=10): read is one-hot for rows 0..3, 12 beats are emitted, and out_last appears only on beat 12.
